// File: rtl/selftrigger_pkg.sv
// Shared constants, FSM state type and header formatting for the self-trigger event capture block.
package selftrigger_pkg;

   localparam logic [7:0] EVT_MARKER = 8'hA5;
   localparam int HDR_WORDS = 4;
   localparam int SAMPLE_W = 14;
   localparam int STREAM_W = 16;
   localparam int TS_W = 48;

   typedef enum logic [1:0] {
      ST_HOLDOFF,
      ST_IDLE,
      ST_CAPTURE,
      ST_READOUT
   } state_t;

   typedef struct packed {
      logic last;
      logic [STREAM_W-1:0] data;
   } stream_word_t;

   // Header word sel: 0 = marker/event number, 1..3 = timestamp from most to least significant.
   function automatic logic [STREAM_W-1:0] header_word(input logic [1:0] sel,
                                                       input logic [7:0] evt,
                                                       input logic [TS_W-1:0] ts);
      logic [STREAM_W-1:0] w;
      case (sel)
         2'd0: w = {EVT_MARKER, evt};
         2'd1: w = ts[47:32];
         2'd2: w = ts[31:16];
         default: w = ts[15:0];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/selftrigger_ring_buffer.sv
// Simple dual-port sample history RAM with a write enable and a registered, one-cycle-latency read port.
module selftrigger_ring_buffer
   import selftrigger_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = SAMPLE_W
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/selftrigger_event_capture.sv
// Keeps a circular pre-trigger history, closes a fixed window around an accepted trigger and
// streams it out as header words followed by samples on a valid/ready interface.
module selftrigger_event_capture
   import selftrigger_pkg::*;
#(
   parameter int ADDR_W      = 9,
   parameter int PRE_SAMPLES = 64,
   parameter int WINDOW      = 256
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] din,
   input  logic                trigger,
   input  logic [TS_W-1:0]     timestamp,
   output logic [STREAM_W-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last,
   output logic [15:0]         missed_count
);

   localparam int EVT_WORDS = WINDOW + HDR_WORDS;
   localparam int IDX_W = $clog2(EVT_WORDS);
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] PRE_OFFSET = ADDR_W'(PRE_SAMPLES);
   localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(PRE_SAMPLES);
   localparam logic [CNT_W-1:0] POST_LOAD = CNT_W'(WINDOW - PRE_SAMPLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(EVT_WORDS - 1);
   localparam logic [IDX_W-1:0] HDR_IDX = IDX_W'(HDR_WORDS);

   state_t state, state_next;

   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] holdoff_cnt, post_cnt;
   logic [TS_W-1:0] ts_reg;
   logic [7:0] event_cnt;
   logic wr_en, accept, reject, in_readout;

   logic [IDX_W-1:0] issue_idx;
   logic issue_done, issue, issue_hdr;
   logic [SAMPLE_W-1:0] rd_data;

   logic p_valid, p_hdr, p_last;
   logic [STREAM_W-1:0] p_hdr_word;
   stream_word_t push_word, q0, q1;
   logic [1:0] fifo_count, fifo_after;
   logic pop, finish;

   selftrigger_ring_buffer #(
      .ADDR_W(ADDR_W),
      .DATA_W(SAMPLE_W)
   ) u_ring (
      .clk(clk),
      .wr_en(wr_en),
      .wr_addr(wr_ptr),
      .wr_data(din),
      .rd_en(issue && !issue_hdr),
      .rd_addr(rd_ptr),
      .rd_data(rd_data)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_HOLDOFF;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_HOLDOFF: if (wr_en && holdoff_cnt <= 1) state_next = ST_IDLE;
         ST_IDLE:    if (accept) state_next = (POST_LOAD == '0) ? ST_READOUT : ST_CAPTURE;
         ST_CAPTURE: if (wr_en && post_cnt == 1) state_next = ST_READOUT;
         ST_READOUT: if (finish) state_next = ST_HOLDOFF;
         default:    state_next = ST_HOLDOFF;
      endcase
   end

   always_comb begin
      wr_en      = 1'b0;
      accept     = 1'b0;
      reject     = 1'b0;
      in_readout = 1'b0;
      unique case (state)
         ST_HOLDOFF, ST_CAPTURE: begin
            wr_en  = enable;
            reject = enable && trigger;
         end
         ST_IDLE: begin
            wr_en  = enable;
            accept = enable && trigger;
         end
         ST_READOUT: begin
            in_readout = 1'b1;
            reject     = enable && trigger;
         end
         default: ;
      endcase
   end

   // rd_ptr holds the window start from the accepted trigger and then walks the window during readout.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         holdoff_cnt  <= HOLDOFF_LOAD;
         post_cnt     <= '0;
         ts_reg       <= '0;
         event_cnt    <= '0;
         missed_count <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (state == ST_HOLDOFF && wr_en) holdoff_cnt <= holdoff_cnt - 1'b1;
         if (finish) begin
            holdoff_cnt <= HOLDOFF_LOAD;
            event_cnt   <= event_cnt + 1'b1;
         end
         if (accept) begin
            rd_ptr   <= wr_ptr - PRE_OFFSET;
            ts_reg   <= timestamp;
            post_cnt <= POST_LOAD;
         end else begin
            if (state == ST_CAPTURE && wr_en) post_cnt <= post_cnt - 1'b1;
            if (issue && !issue_hdr) rd_ptr <= rd_ptr + 1'b1;
         end
         if (reject && missed_count != 16'hFFFF) missed_count <= missed_count + 1'b1;
      end
   end

   // A word is issued only if the skid register will still have room when it lands a cycle later.
   assign pop        = out_valid && out_ready;
   assign finish     = in_readout && pop && q0.last;
   assign fifo_after = fifo_count + {1'b0, p_valid} - {1'b0, pop};
   assign issue      = in_readout && !issue_done && (fifo_after < 2'd2);
   assign issue_hdr  = issue_idx < HDR_IDX;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         issue_idx  <= '0;
         issue_done <= 1'b0;
         p_valid    <= 1'b0;
         p_hdr      <= 1'b0;
         p_last     <= 1'b0;
         p_hdr_word <= '0;
      end else begin
         p_valid <= issue;
         if (issue) begin
            p_hdr      <= issue_hdr;
            p_last     <= (issue_idx == LAST_IDX);
            p_hdr_word <= header_word(issue_idx[1:0], event_cnt, ts_reg);
            issue_idx  <= issue_idx + 1'b1;
            if (issue_idx == LAST_IDX) issue_done <= 1'b1;
         end
         if (finish) begin
            issue_idx  <= '0;
            issue_done <= 1'b0;
         end
      end
   end

   assign push_word.data = p_hdr ? p_hdr_word : {2'b00, rd_data};
   assign push_word.last = p_last;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q0         <= '0;
         q1         <= '0;
         fifo_count <= '0;
      end else begin
         fifo_count <= fifo_after;
         if (pop) begin
            if (fifo_count == 2'd2) begin
               q0 <= q1;
               if (p_valid) q1 <= push_word;
            end else if (p_valid) begin
               q0 <= push_word;
            end
         end else if (p_valid) begin
            if (fifo_count == 2'd0) q0 <= push_word;
            else q1 <= push_word;
         end
      end
   end

   assign out_valid = (fifo_count != 2'd0);
   assign out_data  = q0.data;
   assign out_last  = out_valid && q0.last;

endmodule

// File: tb/tb_selftrigger_event_capture.sv
// Directed self-checking bench: capture windows, stalled readout, rejected triggers, address wrap and mid-readout reset.
module tb_selftrigger_event_capture;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [13:0] din = '0;
   logic        trigger = 1'b0;
   logic [47:0] timestamp = '0;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_last;
   logic [15:0] missed_count;

   int total = 0;
   int bad = 0;
   int wc = 0;

   selftrigger_event_capture #(
      .ADDR_W(9),
      .PRE_SAMPLES(64),
      .WINDOW(256)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .din(din),
      .trigger(trigger),
      .timestamp(timestamp),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last(out_last),
      .missed_count(missed_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drives cycles with din tracking the write count; trig is held for every cycle of the call.
   task automatic applyStimulus(input int cycles, input bit en, input bit trig);
      for (int i = 0; i < cycles; i++) begin
         enable  = en;
         trigger = trig;
         din     = 14'(wc % 16384);
         step();
         if (en) wc++;
      end
      trigger = 1'b0;
      enable  = 1'b1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      enable  = 1'b0;
      trigger = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      reset_n = 1'b1;
      wc = 0;
   endtask

   function automatic logic [15:0] exp_word(input int n, input logic [7:0] evt, input logic [47:0] ts, input int start);
      case (n)
         0: return {8'hA5, evt};
         1: return ts[47:32];
         2: return ts[31:16];
         3: return ts[15:0];
         default: return 16'((start + n - 4) % 16384);
      endcase
   endfunction

   task automatic collect_event(input string tag, input logic [7:0] evt, input logic [47:0] ts, input int start,
                                input bit rand_ready, input int trig_word, input int abort_word);
      int n = 0;
      int cycles = 0;
      bit stalled = 0;
      bit trig_done = 0;
      logic [15:0] held = '0;
      enable = 1'b1;
      while (n < 260 && cycles < 4000) begin
         if (abort_word >= 0 && n == abort_word) begin
            reset_n = 1'b0;
            out_ready = 1'b1;
            step();
            checkOutput({tag, "_abort_valid"}, 32'(out_valid), 32'd0);
            checkOutput({tag, "_abort_last"}, 32'(out_last), 32'd0);
            reset_n = 1'b1;
            wc = 0;
            return;
         end
         if (stalled) begin
            checkOutput($sformatf("%s_hold_valid_%0d", tag, n), 32'(out_valid), 32'd1);
            checkOutput($sformatf("%s_hold_data_%0d", tag, n), 32'(out_data), 32'(held));
         end
         out_ready = rand_ready ? (($urandom % 2) == 0) : 1'b1;
         trigger = (!trig_done && n == trig_word);
         if (trigger) trig_done = 1;
         stalled = 0;
         if (out_valid) begin
            if (out_ready) begin
               checkOutput($sformatf("%s_word_%0d", tag, n), 32'(out_data), 32'(exp_word(n, evt, ts, start)));
               checkOutput($sformatf("%s_last_%0d", tag, n), 32'(out_last), 32'(n == 259));
               n++;
            end else begin
               stalled = 1;
               held = out_data;
            end
         end
         step();
         trigger = 1'b0;
         cycles++;
      end
      out_ready = 1'b1;
      checkOutput({tag, "_word_count"}, 32'(n), 32'd260);
   endtask

   initial begin
      // Reset state.
      do_reset();
      checkOutput("reset_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_last", 32'(out_last), 32'd0);
      checkOutput("reset_data", 32'(out_data), 32'd0);
      checkOutput("reset_missed", 32'(missed_count), 32'd0);

      $display("[TB] step 1: trigger at write 1000, out_ready=1");
      timestamp = 48'h0000_1234_5678;
      applyStimulus(1000, 1, 0);
      applyStimulus(1, 1, 1);
      applyStimulus(191, 1, 0);
      collect_event("ev1", 8'h00, 48'h0000_1234_5678, 936, 0, -1, -1);
      checkOutput("ev1_missed", 32'(missed_count), 32'd0);
      checkOutput("ev1_idle_valid", 32'(out_valid), 32'd0);

      $display("[TB] step 2: same event with random out_ready");
      do_reset();
      applyStimulus(1000, 1, 0);
      applyStimulus(1, 1, 1);
      applyStimulus(191, 1, 0);
      collect_event("ev2", 8'h00, 48'h0000_1234_5678, 936, 1, -1, -1);
      checkOutput("ev2_missed", 32'(missed_count), 32'd0);

      $display("[TB] step 3: trigger during holdoff, then accepted trigger");
      do_reset();
      timestamp = 48'hABCD_0000_0042;
      applyStimulus(10, 1, 0);
      applyStimulus(5, 0, 1);
      checkOutput("ev3_disabled_missed", 32'(missed_count), 32'd0);
      applyStimulus(1, 1, 1);
      checkOutput("ev3_holdoff_missed", 32'(missed_count), 32'd1);
      applyStimulus(89, 1, 0);
      applyStimulus(1, 1, 1);
      applyStimulus(191, 1, 0);
      collect_event("ev3", 8'h00, 48'hABCD_0000_0042, 36, 0, -1, -1);
      checkOutput("ev3_missed", 32'(missed_count), 32'd1);

      $display("[TB] step 4: triggers during capture and readout");
      do_reset();
      timestamp = 48'h0001_0002_0003;
      applyStimulus(100, 1, 0);
      applyStimulus(1, 1, 1);
      applyStimulus(49, 1, 0);
      applyStimulus(1, 1, 1);
      checkOutput("ev4_capture_missed", 32'(missed_count), 32'd1);
      applyStimulus(141, 1, 0);
      collect_event("ev4a", 8'h00, 48'h0001_0002_0003, 36, 0, 30, -1);
      checkOutput("ev4_readout_missed", 32'(missed_count), 32'd2);
      applyStimulus(63, 1, 0);
      checkOutput("ev4_single_event", 32'(out_valid), 32'd0);
      applyStimulus(1, 1, 1);
      checkOutput("ev4_late_holdoff_missed", 32'(missed_count), 32'd3);
      timestamp = 48'h0000_0000_0777;
      applyStimulus(1, 1, 1);
      checkOutput("ev4_accept_missed", 32'(missed_count), 32'd3);
      applyStimulus(191, 1, 0);
      collect_event("ev4b", 8'h01, 48'h0000_0000_0777, 292, 0, -1, -1);

      $display("[TB] step 5: window straddling the address wrap");
      do_reset();
      timestamp = 48'hFFFF_EEEE_DDDD;
      applyStimulus(480, 1, 0);
      applyStimulus(1, 1, 1);
      applyStimulus(191, 1, 0);
      collect_event("ev5", 8'h00, 48'hFFFF_EEEE_DDDD, 416, 1, -1, -1);

      $display("[TB] step 6: reset in the middle of readout");
      do_reset();
      timestamp = 48'h0000_0000_0100;
      applyStimulus(100, 1, 0);
      applyStimulus(1, 1, 1);
      applyStimulus(191, 1, 0);
      collect_event("ev6a", 8'h00, 48'h0000_0000_0100, 36, 0, -1, 100);
      checkOutput("ev6_missed_cleared", 32'(missed_count), 32'd0);
      applyStimulus(64, 1, 0);
      timestamp = 48'h0000_0000_0200;
      applyStimulus(1, 1, 1);
      applyStimulus(191, 1, 0);
      collect_event("ev6b", 8'h00, 48'h0000_0000_0200, 0, 0, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
